// File: rtl/pixel_plotter_pkg.sv
// Shared constants and FSM encoding for the pixel plotter: coordinate/colour widths,
// screen geometry, framebuffer address width and default FIFO depth.
`ifndef X_BITES
`define X_BITES 8
`endif
`ifndef Y_BITES
`define Y_BITES 7
`endif

package pixel_plotter_pkg;

  localparam int X_BITES        = `X_BITES;
  localparam int Y_BITES        = `Y_BITES;
  localparam int COLOR_BITS     = 3;
  localparam int SCREEN_COLS    = 160;
  localparam int SCREEN_ROWS    = 120;
  localparam int FB_ADDR_W      = 15;
  localparam int PIX_FIFO_DEPTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } plot_state_t;

endpackage

// File: rtl/pixel_plotter_if.sv
// Pixel-in / framebuffer-write-out bundle. The plotter takes the slave view; the
// renderer and memory port together drive the master view.
interface pixel_plotter_if
  import pixel_plotter_pkg::*;
#(
  parameter int X_W     = X_BITES,
  parameter int Y_W     = Y_BITES,
  parameter int COLOR_W = COLOR_BITS,
  parameter int ADDR_W  = FB_ADDR_W
);

  logic [X_W-1:0]     in_x;
  logic [Y_W-1:0]     in_y;
  logic [COLOR_W-1:0] in_color;
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic [COLOR_W-1:0] out_color;
  logic               out_write;
  logic               out_ack;
  logic               busy;

  modport master (
    output in_x, in_y, in_color, in_valid, out_ack,
    input  in_ready, out_addr, out_color, out_write, busy
  );

  modport slave (
    input  in_x, in_y, in_color, in_valid, out_ack,
    output in_ready, out_addr, out_color, out_write, busy
  );

endinterface

// File: rtl/pixel_plotter_fifo.sv
// pixel_fifo: synchronous FIFO with full/empty/count; a push while full is dropped
// even when a pop happens in the same cycle, and there is no empty bypass.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; the pointers and count alone define validity,
  // and leaving it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_plotter.sv
// Buffers renderer pixel writes and issues held framebuffer write requests with ack.
// Define PIXEL_PLOTTER_CLIP_EN to drop off-screen pixels and expose clipped_count.
module pixel_plotter
  import pixel_plotter_pkg::*;
#(
  parameter int X_W           = X_BITES,
  parameter int Y_W           = Y_BITES,
  parameter int COLOR_W       = COLOR_BITS,
  parameter int SCREEN_WIDTH  = SCREEN_COLS,
  parameter int SCREEN_HEIGHT = SCREEN_ROWS,
  parameter int ADDR_W        = FB_ADDR_W,
  parameter int FIFO_DEPTH    = PIX_FIFO_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  pixel_plotter_if.slave bus
`ifdef PIXEL_PLOTTER_CLIP_EN
  ,
  output logic [15:0]   clipped_count
`endif
);

  localparam int DATA_W = X_W + Y_W + COLOR_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  if (SCREEN_WIDTH * SCREEN_HEIGHT > (1 << ADDR_W)) begin : g_bad_geometry
    $error("pixel_plotter: screen does not fit in the framebuffer address width");
  end

  plot_state_t        state_q;
  plot_state_t        state_d;
  logic               accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [DATA_W-1:0]  fifo_rdata;
  logic [X_W-1:0]     head_x;
  logic [Y_W-1:0]     head_y;
  logic [COLOR_W-1:0] head_color;
  logic [ADDR_W-1:0]  head_addr;
  logic [ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0] color_q;

  assign bus.in_ready = !reset && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef PIXEL_PLOTTER_CLIP_EN
  logic clip;

  assign clip      = (int'(bus.in_x) >= SCREEN_WIDTH) || (int'(bus.in_y) >= SCREEN_HEIGHT);
  assign fifo_push = accept && !clip;

  always_ff @(posedge clock) begin
    if (reset) begin
      clipped_count <= '0;
    end else if (accept && clip && (clipped_count != 16'hFFFF)) begin
      clipped_count <= clipped_count + 16'd1;
    end
  end
`else
  assign fifo_push = accept;
`endif

  pixel_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({bus.in_x, bus.in_y, bus.in_color}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_x, head_y, head_color} = fifo_rdata;
  // Zero-extend before the multiply so the product is formed at address width.
  assign head_addr = ADDR_W'(head_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(head_x);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.out_ack) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        addr_q  <= head_addr;
        color_q <= head_color;
      end
    end
  end

  assign bus.out_write = (state_q == ST_WRITE);
  assign bus.out_addr  = addr_q;
  assign bus.out_color = color_q;
  assign bus.busy      = (fifo_count != '0) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: vector table, handshake corner sequences and a
// randomized run scored against a queue of expected framebuffer writes.
module tb_pixel_plotter;
  import pixel_plotter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pixel_plotter_if bus ();

`ifdef PIXEL_PLOTTER_CLIP_EN
  logic [15:0] clipped_count;
`endif

  pixel_plotter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef PIXEL_PLOTTER_CLIP_EN
    ,
    .clipped_count (clipped_count)
`endif
  );

  typedef struct {
    int x;
    int y;
    int color;
    int addr;
  } vec_t;

  typedef struct {
    int addr;
    int color;
  } wr_t;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int x, input int y, input int c);
    bus.in_valid = 1'b1;
    bus.in_x     = X_BITES'(x);
    bus.in_y     = Y_BITES'(y);
    bus.in_color = COLOR_BITS'(c);
  endtask

  // Linear framebuffer address of an on-screen pixel, truncated to the 15-bit bus.
  function automatic int ref_addr(input int x, input int y);
    return (y * 160 + x) % 32768;
  endfunction

  function automatic bit off_screen(input int x, input int y);
    return (x >= 160) || (y >= 120);
  endfunction

  initial begin : main
    vec_t table_v[5];
    int   px[9];
    int   py[9];
    int   pc[9];
    wr_t  exp_q[$];
    wr_t  w;
    int   got;
    int   first;
    int   last;
    int   accepted;
    int   clip_total;
    int   x;
    int   y;
    int   c;
    bit   v;

    table_v[0] = '{x: 5,   y: 2,   color: 3, addr: 325};
    table_v[1] = '{x: 159, y: 119, color: 7, addr: 19199};
    table_v[2] = '{x: 0,   y: 0,   color: 0, addr: 0};
    table_v[3] = '{x: 0,   y: 1,   color: 5, addr: 160};
    table_v[4] = '{x: 100, y: 50,  color: 2, addr: 8100};

    for (int i = 0; i < 9; i++) begin
      px[i] = 10 * i + 3;
      py[i] = 13 * i + 1;
      pc[i] = (i + 1) % 8;
    end
    clip_total = 0;

    // Reset state
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_color = '0;
    bus.out_ack  = 1'b0;
    step();
    step();
    check("reset in_ready", 32'(bus.in_ready), 0);
    check("reset out_write", 32'(bus.out_write), 0);
    check("reset out_addr", 32'(bus.out_addr), 0);
    check("reset out_color", 32'(bus.out_color), 0);
    check("reset busy", 32'(bus.busy), 0);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", 32'(bus.in_ready), 1);

    // Single-pixel vectors: write appears two edges after acceptance, for one cycle
    for (int i = 0; i < 5; i++) begin
      offer(table_v[i].x, table_v[i].y, table_v[i].color);
      step();
      bus.in_valid = 1'b0;
      check("tbl no early write", 32'(bus.out_write), 0);
      bus.out_ack = 1'b1;
      step();
      check("tbl out_write", 32'(bus.out_write), 1);
      check("tbl out_addr", 32'(bus.out_addr), 32'(table_v[i].addr));
      check("tbl out_color", 32'(bus.out_color), 32'(table_v[i].color));
      step();
      check("tbl write ends", 32'(bus.out_write), 0);
      check("tbl busy clear", 32'(bus.busy), 0);
      bus.out_ack = 1'b0;
    end

    // Back-to-back: four pixels on consecutive cycles give four consecutive writes
    bus.out_ack = 1'b1;
    got   = 0;
    first = -1;
    last  = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 4) offer(px[cyc], py[cyc], pc[cyc]);
      else         bus.in_valid = 1'b0;
      if (bus.out_write) begin
        if (got < 4) begin
          check("b2b addr", 32'(bus.out_addr), 32'(ref_addr(px[got], py[got])));
          check("b2b color", 32'(bus.out_color), 32'(pc[got]));
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      step();
    end
    check("b2b write count", 32'(got), 4);
    check("b2b first write cycle", 32'(first), 2);
    check("b2b contiguous", 32'(last - first), 3);
    bus.out_ack = 1'b0;

    // Backpressure: eight buffered plus one held, then drain all nine in order
    accepted = 0;
    for (int cyc = 0; cyc < 30 && accepted < 9; cyc++) begin
      offer(px[accepted], py[accepted], pc[accepted]);
      if (bus.in_ready) accepted++;
      step();
    end
    check("bp accepted", 32'(accepted), 9);
    offer(1, 1, 1);
    check("bp in_ready low when full", 32'(bus.in_ready), 0);
    check("bp busy", 32'(bus.busy), 1);
    step();
    check("bp still full", 32'(bus.in_ready), 0);
    check("bp held addr", 32'(bus.out_addr), 32'(ref_addr(px[0], py[0])));
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && (bus.busy || got == 0); cyc++) begin
      if (bus.out_write && bus.out_ack) begin
        if (got < 9) begin
          check("bp drain addr", 32'(bus.out_addr), 32'(ref_addr(px[got], py[got])));
          check("bp drain color", 32'(bus.out_color), 32'(pc[got]));
        end
        got++;
      end
      step();
    end
    check("bp drained count", 32'(got), 9);
    check("bp busy after drain", 32'(bus.busy), 0);
    bus.out_ack = 1'b0;

    // Held request: stable address/colour while unacknowledged, single write on ack
    offer(37, 88, 6);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int cyc = 0; cyc < 5; cyc++) begin
      check("hold out_write", 32'(bus.out_write), 1);
      check("hold out_addr", 32'(bus.out_addr), 32'(ref_addr(37, 88)));
      check("hold out_color", 32'(bus.out_color), 6);
      step();
    end
    bus.out_ack = 1'b1;
    step();
    check("hold single write", 32'(bus.out_write), 0);
    step();
    check("hold no repeat", 32'(bus.out_write), 0);
    bus.out_ack = 1'b0;

    // Reset mid-write: queued pixels are discarded, ack during reset is ignored
    for (int i = 0; i < 3; i++) begin
      offer(px[i], py[i], pc[i]);
      step();
    end
    bus.in_valid = 1'b0;
    check("rst pre write active", 32'(bus.out_write), 1);
    reset       = 1'b1;
    bus.out_ack = 1'b1;
    step();
    check("rst out_write", 32'(bus.out_write), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst in_ready during reset", 32'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    check("rst in_ready after", 32'(bus.in_ready), 1);
    got = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (bus.out_write) got++;
      step();
    end
    check("rst discarded writes", 32'(got), 0);
    bus.out_ack = 1'b0;

`ifdef PIXEL_PLOTTER_CLIP_EN
    // Clipping: off-screen pixels are accepted but never written
    bus.out_ack = 1'b1;
    offer(160, 0, 1);
    check("clip in_ready", 32'(bus.in_ready), 1);
    step();
    clip_total++;
    offer(0, 120, 2);
    step();
    clip_total++;
    bus.in_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (bus.out_write) got++;
      step();
    end
    check("clip no write", 32'(got), 0);
    check("clip count", 32'(clipped_count), 32'(clip_total));
    bus.out_ack = 1'b0;
`endif

    // Randomized traffic against the expected-write queue
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 127);
      end else begin
        x = $urandom_range(0, 159);
        y = $urandom_range(0, 119);
      end
      c = $urandom_range(0, 7);
      offer(x, y, c);
      bus.in_valid = v;
      bus.out_ack  = ($urandom_range(0, 9) < 6);
      if (v && bus.in_ready) begin
`ifdef PIXEL_PLOTTER_CLIP_EN
        if (off_screen(x, y)) clip_total++;
        else                  exp_q.push_back('{addr: ref_addr(x, y), color: c});
`else
        exp_q.push_back('{addr: ref_addr(x, y), color: c});
`endif
      end
      if (bus.out_write) begin
        if (exp_q.size() == 0) begin
          check("rnd unexpected write", 32'(bus.out_write), 0);
        end else begin
          w = exp_q[0];
          check("rnd addr", 32'(bus.out_addr), 32'(w.addr));
          check("rnd color", 32'(bus.out_color), 32'(w.color));
          if (bus.out_ack) void'(exp_q.pop_front());
        end
      end
      step();
    end

    // Drain whatever is left
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b1;
    for (int cyc = 0; cyc < 40 && (bus.busy || exp_q.size() != 0); cyc++) begin
      if (bus.out_write) begin
        if (exp_q.size() == 0) begin
          check("drain unexpected write", 32'(bus.out_write), 0);
        end else begin
          w = exp_q[0];
          check("drain addr", 32'(bus.out_addr), 32'(w.addr));
          check("drain color", 32'(bus.out_color), 32'(w.color));
          void'(exp_q.pop_front());
        end
      end
      step();
    end
    check("drain queue empty", 32'(exp_q.size()), 0);
    check("drain busy", 32'(bus.busy), 0);
`ifdef PIXEL_PLOTTER_CLIP_EN
    check("rnd clip count", 32'(clipped_count), 32'(clip_total));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_plotter.md
Name: pixel_plotter

Overview:
- Consumer end of the glyph pixel stream: accepts (x, y, colour) pixel writes from character/square renderers, buffers them in a small FIFO, converts each to a linear framebuffer address, and issues write requests to the framebuffer memory port with a request/acknowledge handshake.
- Sits between the rendering blocks and the VGA framebuffer arbiter. Decouples renderer cadence from memory-port stalls through backpressure (in_ready).

Parameters:
- X_W, 8, pixel x coordinate width (matches `X_BITES)
- Y_W, 7, pixel y coordinate width (matches `Y_BITES)
- COLOR_W, 3, colour width
- SCREEN_WIDTH, 160, pixels per row
- SCREEN_HEIGHT, 120, rows
- ADDR_W, 15, framebuffer address width
- FIFO_DEPTH, 8, buffered pixels; power of two

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_x  in  X_W  pixel x
- in_y  in  Y_W  pixel y
- in_color  in  COLOR_W  pixel colour
- in_valid  in  1  pixel offered this cycle
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready
- out_addr  out  ADDR_W  linear address y*SCREEN_WIDTH + x
- out_color  out  COLOR_W  colour to write
- out_write  out  1  write request; held until acknowledged
- out_ack  in  1  memory accepted the current write
- busy  out  1  FIFO non-empty or write outstanding

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. out_write=0, out_addr=0, out_color=0, busy=0. FIFO pointers and count are 0. FSM is IDLE.
- FIFO: push when in_valid && in_ready. in_ready = (count != FIFO_DEPTH). No push while full, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full leave count unchanged. No empty bypass.
- FSM states IDLE and WRITE:
  - IDLE: if the FIFO is non-empty, pop the head, register out_addr/out_color, and go to WRITE. Otherwise stay in IDLE.
  - WRITE: out_write=1. out_addr and out_color stay stable until out_ack.
  - On out_ack with FIFO non-empty: pop the next entry the same cycle and stay in WRITE. This gives back-to-back writes at 1 pixel/cycle.
  - On out_ack with FIFO empty: go to IDLE; out_write=0 next cycle.
- Latency: a pixel accepted at edge N appears with out_write=1 in cycle N+2 (FIFO empty, FSM idle, memory idle).
- Address arithmetic: out_addr = y*SCREEN_WIDTH + x. Compute at ADDR_W bits; y and x are zero-extended before multiply/add. No overflow for in-range coordinates: max 119*160+159 = 19199 < 2^15.
- out_ack while out_write=0 is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- busy = (count != 0) || (state == WRITE).
- Reset mid-operation:
  - The pending write is abandoned and buffered pixels are discarded.
  - out_write is 0 in the cycle after the reset edge.
  - An out_ack arriving while reset is asserted is ignored.

Optional Feature:
- Macro PIXEL_PLOTTER_CLIP_EN.
- Defined:
  - Pixels with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT are accepted (in_ready unaffected) but never written to the FIFO.
  - A 16-bit saturating output clipped_count (reset 0) increments once per clipped pixel.
- Undefined:
  - Every accepted pixel is written.
  - Out-of-range addresses pass through truncated to ADDR_W.
  - No clipped_count port.

Decomposition:
- Shared package / defines file holds:
  - `X_BITES, `Y_BITES, COLOR width, SCREEN_WIDTH/SCREEN_HEIGHT constants
  - FB_ADDR width
  - FSM state encoding (IDLE=0, WRITE=1)
- One natural sub-module: pixel_fifo, a synchronous FIFO with parameterised width/depth and full/empty/count outputs. Data width = X_W+Y_W+COLOR_W.

Test Plan:
- Single pixel: x=5, y=2, color=3, out_ack tied 1 -> out_write high exactly 1 cycle at N+2, out_addr=325, out_color=3; busy returns to 0.
- Back-to-back: 4 pixels on consecutive cycles, out_ack=1 -> 4 consecutive out_write cycles; addresses match y*160+x in order.
- Backpressure: out_ack=0, push 9 pixels -> 8 entries buffered plus 1 held in WRITE; in_ready=0 after 9 accepts; raise out_ack -> all 9 written in order, none lost.
- Held request: out_ack=0 for 5 cycles -> out_addr/out_color stable and out_write=1 throughout; single write on ack.
- Corner address: x=159, y=119 -> out_addr=19199.
- Reset mid-write: 3 pixels queued, reset during WRITE -> next cycle out_write=0, busy=0, in_ready=1 after reset. With CLIP_EN, x=160 -> no write, clipped_count=1.
